game_clock_gen: RTL and testbench
=================================

// Module: game_clock_gen
// PURPOSE
//  Single-clock timebase for the game logic.
//  - Free-running 32-bit cycle counter clk_div: feeds clock-select taps
//    (e.g. bit 17 ~1.3 ms at 100 MHz) and acts as the pseudo-random seed source.
//  - 100 ms square wave clk_100ms: drives the game-state update process.
//  - One-cycle ticks at 100 ms and 1 ms for logic that stays in the clk domain.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  input clock frequency in Hz
//  PERIOD_MS    100          period of clk_100ms in ms
//  DIV_W        32           width of clk_div
// PORTS
//  clk         in   1      system clock, all state updates on posedge
//  rst         in   1      asynchronous, active-low reset
//  clk_div     out  DIV_W  free-running cycle counter
//  clk_100ms   out  1      square wave, period PERIOD_MS, 50% duty
//  tick_100ms  out  1      1-cycle pulse, coincident with clk_100ms rising
//  tick_1ms    out  1      1-cycle pulse every CLK_FREQ_HZ/1000 cycles
// BEHAVIOUR
//  - Derived constants (elaboration time, 64-bit arithmetic):
//    - HALF = max(1, (CLK_FREQ_HZ/1000)*PERIOD_MS/2)
//    - MS = max(1, CLK_FREQ_HZ/1000)
//  - Reset:
//    - rst=0 asynchronously forces clk_div=0, clk_100ms=0, tick_100ms=0, tick_1ms=0.
//    - Also clears the internal half-period counter hcnt and ms counter mcnt.
//    - Reset is honoured mid-period; no partial state survives.
//  - clk_div: +1 every posedge while rst=1; wraps 2^DIV_W-1 -> 0 with no flag.
//  - hcnt:
//    - Counts 0..HALF-1.
//    - On posedge with hcnt==HALF-1: hcnt<=0 and clk_100ms toggles.
//    - Otherwise hcnt increments.
//    - First rise of clk_100ms occurs on the HALF-th posedge after reset release.
//    - Thereafter clk_100ms is high HALF cycles, then low HALF cycles.
//  - tick_100ms:
//    - Registered; =1 only on the posedge where clk_100ms goes 0->1.
//    - Deasserts on the next posedge.
//  - mcnt and tick_1ms:
//    - mcnt counts 0..MS-1.
//    - tick_1ms=1 for exactly the cycle after mcnt wraps (period MS cycles).
//    - First assertion on the MS-th posedge after reset release.
//  - All outputs are registers; no combinational path from rst release to outputs.
//  - Counters are independent: tick_100ms and tick_1ms may assert in the same cycle.
// TESTING (bench params CLK_FREQ_HZ=20_000, PERIOD_MS=1 -> HALF=10, MS=20)
//  - Reset hold: rst=0 for 5 cycles -> all outputs 0.
//    Assert rst=0 asynchronously mid-cycle -> outputs 0 before next edge.
//  - Release rst; count edges:
//    - clk_div==N after N posedges.
//    - clk_100ms rises at edge 10, falls at edge 20, rises at edge 30.
//  - tick_100ms high only after edges 10, 30, 50; 1 cycle wide each time.
//  - tick_1ms high only after edges 20, 40, 60; same cycles as clk_100ms falling.
//  - Wrap: force clk_div=32'hFFFF_FFFF -> next edge 0, clk_100ms phase unaffected.
//  - Mid-period reset: rst=0 at edge 15, release -> clk_100ms rises 10 edges later.
//    clk_div restarts from 0.

Source files
------------

// File: rtl/game_clock_gen.sv
// Game timebase: free-running cycle counter, 100 ms square wave,
// 100 ms rising-edge tick and 1 ms tick, all in the clk domain.
//
// Ports:
//   clk        in   system clock, all state updates on posedge
//   rst        in   asynchronous active-low reset
//   clk_div    out  free-running DIV_W-bit cycle counter
//   clk_100ms  out  square wave, period PERIOD_MS, 50% duty
//   tick_100ms out  1-cycle pulse on each clk_100ms rising edge
//   tick_1ms   out  1-cycle pulse every CLK_FREQ_HZ/1000 cycles

module game_clock_gen #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned PERIOD_MS   = 100,
    parameter int unsigned DIV_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic [DIV_W-1:0] clk_div,
    output logic             clk_100ms,
    output logic             tick_100ms,
    output logic             tick_1ms
);

    // Derived constants in 64-bit so large frequencies times
    // long periods cannot overflow during elaboration.
    localparam logic [63:0] MS_RAW   = 64'(CLK_FREQ_HZ) / 64'd1000;
    localparam logic [63:0] HALF_RAW = (MS_RAW * 64'(PERIOD_MS)) / 64'd2;
    localparam logic [63:0] MS       = (MS_RAW == 64'd0) ? 64'd1 : MS_RAW;
    localparam logic [63:0] HALF     = (HALF_RAW == 64'd0) ? 64'd1 : HALF_RAW;

    localparam int unsigned HW = (HALF > 64'd1) ? $clog2(HALF) : 1;
    localparam int unsigned MW = (MS > 64'd1) ? $clog2(MS) : 1;

    localparam logic [HW-1:0] HALF_LAST = HW'(HALF - 64'd1);
    localparam logic [MW-1:0] MS_LAST   = MW'(MS - 64'd1);

    logic [DIV_W-1:0] clk_div_q, clk_div_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             clk_100ms_q, clk_100ms_d;
    logic             tick_100ms_q, tick_100ms_d;
    logic             tick_1ms_q, tick_1ms_d;

    logic             h_wrap;
    logic             m_wrap;

    always_comb begin
        h_wrap = (hcnt_q == HALF_LAST);
        m_wrap = (mcnt_q == MS_LAST);

        clk_div_d    = clk_div_q + DIV_W'(1);

        hcnt_d       = h_wrap ? '0 : hcnt_q + HW'(1);
        clk_100ms_d  = clk_100ms_q ^ h_wrap;
        // Rising edge happens only when the wave is currently low.
        tick_100ms_d = h_wrap & ~clk_100ms_q;

        mcnt_d       = m_wrap ? '0 : mcnt_q + MW'(1);
        tick_1ms_d   = m_wrap;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_div_q    <= '0;
            hcnt_q       <= '0;
            mcnt_q       <= '0;
            clk_100ms_q  <= 1'b0;
            tick_100ms_q <= 1'b0;
            tick_1ms_q   <= 1'b0;
        end else begin
            clk_div_q    <= clk_div_d;
            hcnt_q       <= hcnt_d;
            mcnt_q       <= mcnt_d;
            clk_100ms_q  <= clk_100ms_d;
            tick_100ms_q <= tick_100ms_d;
            tick_1ms_q   <= tick_1ms_d;
        end
    end

    assign clk_div    = clk_div_q;
    assign clk_100ms  = clk_100ms_q;
    assign tick_100ms = tick_100ms_q;
    assign tick_1ms   = tick_1ms_q;

endmodule

// File: tb/tb_game_clock_gen.sv
// Randomised scoreboard bench for game_clock_gen.
// Reference model derives every output from edges since reset release.

module tb_game_clock_gen;

    localparam int unsigned F_HZ  = 20_000;
    localparam int unsigned P_MS  = 1;
    localparam int unsigned DW    = 8;
    localparam int          HALF  = 10;
    localparam int          MS    = 20;
    localparam int          NCYC  = 800;

    typedef struct packed {
        logic [DW-1:0] div;
        logic          c100;
        logic          t100;
        logic          t1;
    } obs_t;

    logic          clk;
    logic          rst;
    logic [DW-1:0] clk_div;
    logic          clk_100ms;
    logic          tick_100ms;
    logic          tick_1ms;

    obs_t exp_q[$];
    int   vectors;
    int   miscompares;

    game_clock_gen #(
        .CLK_FREQ_HZ(F_HZ),
        .PERIOD_MS  (P_MS),
        .DIV_W      (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_div   (clk_div),
        .clk_100ms (clk_100ms),
        .tick_100ms(tick_100ms),
        .tick_1ms  (tick_1ms)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after n posedges since reset release.
    function automatic obs_t model(input longint n);
        obs_t o;
        o.div  = DW'(n % (64'd1 << DW));
        o.c100 = ((n / HALF) % 2) == 1;
        o.t100 = (n % (2 * HALF)) == HALF;
        o.t1   = (n > 0) && ((n % MS) == 0);
        return o;
    endfunction

    // Directed opening (hold, long run, mid-period reset, wrap),
    // then random short reset pulses.
    function automatic logic rst_for(input int c);
        if (c < 5)   return 1'b0;
        if (c < 75)  return 1'b1;
        if (c < 78)  return 1'b0;
        if (c < 93)  return 1'b1;
        if (c < 96)  return 1'b0;
        if (c < 416) return 1'b1;
        return ($urandom_range(0, 59) != 0);
    endfunction

    // Driver: changes rst just after negedge (asynchronous w.r.t.
    // posedge) and pushes two expectations: one for the mid-cycle
    // sample, one for the sample after the following posedge.
    initial begin
        longint n;
        logic   r;
        n   = 0;
        rst = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            #1;
            r   = rst_for(c);
            rst = r;
            if (!r) n = 0;
            exp_q.push_back(model(n));
            if (r) n++;
            exp_q.push_back(model(n));
        end
    end

    task automatic check(input string tag);
        obs_t a, e;
        a = '{div: clk_div, c100: clk_100ms, t100: tick_100ms, t1: tick_1ms};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: no expectation queued, got %h", tag, a);
            return;
        end
        e = exp_q.pop_front();
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t: got div=%0d c100=%b t100=%b t1=%b, want div=%0d c100=%b t100=%b t1=%b",
                     tag, $time, a.div, a.c100, a.t100, a.t1,
                     e.div, e.c100, e.t100, e.t1);
        end
    endtask

    // Monitor: samples mid-cycle (after any async reset) and
    // just after each posedge.
    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            #3;
            check("mid_cycle");
            @(posedge clk);
            #2;
            check("post_edge");
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: got %0d queued, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #(NCYC * 10 * 4);
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
